// File: rtl/btn_debounce_1ms.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce_1ms
//  Description : Push-button debouncer and classifier driven by a 1 ms tick.
//                Two-flop synchronizer, tick-counted stability window for
//                press and release, and a one-shot long-press event.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce_1ms #(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int CNT_W       = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_1ms,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    // Terminal counts: acceptance happens on the tick that would take the
    // counter from LAST to LAST+1, so the counter never exceeds LAST.
    localparam logic [CNT_W-1:0] c_deb_last  = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_RELEASED     = 3'd0,
        S_PRESS_WAIT   = 3'd1,
        S_PRESSED      = 3'd2,
        S_HELD         = 3'd3,
        S_RELEASE_WAIT = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_btn_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_long_fired;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;

    // Two-flop synchronizer for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2;

    // Debounce / classification state machine with registered outputs.
    // A btn_s change always wins over a coincident tick, so that tick is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RELEASED;
            r_cnt        <= '0;
            r_long_fired <= 1'b0;
            r_level      <= 1'b0;
            r_press      <= 1'b0;
            r_release    <= 1'b0;
            r_long       <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            case (r_state)
                S_RELEASED: begin
                    if (w_btn_s) begin
                        r_state <= S_PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                S_PRESS_WAIT: begin
                    if (!w_btn_s) begin
                        r_state <= S_RELEASED;
                        r_cnt   <= '0;
                    end else if (tick_1ms) begin
                        if (r_cnt == c_deb_last) begin
                            r_state      <= S_PRESSED;
                            r_cnt        <= '0;
                            r_level      <= 1'b1;
                            r_press      <= 1'b1;
                            r_long_fired <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end
                S_PRESSED: begin
                    if (!w_btn_s) begin
                        r_state <= S_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end else if (tick_1ms) begin
                        if (r_cnt == c_long_last) begin
                            r_state      <= S_HELD;
                            r_cnt        <= '0;
                            r_long       <= 1'b1;
                            r_long_fired <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end
                S_HELD: begin
                    if (!w_btn_s) begin
                        r_state <= S_RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                S_RELEASE_WAIT: begin
                    if (w_btn_s) begin
                        // Release bounce: resume where the press left off,
                        // but an unfired long-press count starts over.
                        r_state <= r_long_fired ? S_HELD : S_PRESSED;
                        r_cnt   <= '0;
                    end else if (tick_1ms) begin
                        if (r_cnt == c_deb_last) begin
                            r_state   <= S_RELEASED;
                            r_cnt     <= '0;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_one;
                        end
                    end
                end
                default: begin
                    r_state <= S_RELEASED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_1ms.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debounce_1ms
//  Description : Self-checking bench for btn_debounce_1ms. A behavioural model
//                tracks "ticks since btn_s last changed" and "ticks held since
//                acceptance or last re-press", compared every cycle; directed
//                scenarios pin exact tick positions of the events.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debounce_1ms;

    localparam int DEB  = 3;
    localparam int LONG = 5;

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic tick_1ms = 1'b0;
    logic btn_in   = 1'b0;
    logic btn_level, press_pulse, release_pulse, long_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_no  = 0;
    int tdiv     = 0;
    int tick_mode = 0;   // 0: one tick every 10 clk, 1: random ticks
    int n_press = 0, n_release = 0, n_long = 0;
    int press_tick = -1, release_tick = -1, long_tick = -1;

    btn_debounce_1ms #(
        .DEBOUNCE_MS (DEB),
        .LONG_MS     (LONG),
        .CNT_W       (11)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tick_1ms      (tick_1ms),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    // Tick source, changed on the falling edge so it is stable at rising edges
    always @(negedge clk) begin
        if (tick_mode == 0) tick_1ms = (tdiv == 9);
        else                tick_1ms = ($urandom_range(0, 5) == 0);
        tdiv = (tdiv == 9) ? 0 : tdiv + 1;
    end

    always @(posedge clk) begin
        if (tick_1ms) tick_no = tick_no + 1;
    end

    // ---------------- behavioural model ----------------
    logic m_s1, m_s2, m_prev, m_bs, m_changed;
    int   m_run, m_long_run;
    logic m_fired;
    logic m_level, m_press, m_release, m_long;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_prev = 0;
            m_run = 0; m_long_run = 0; m_fired = 0;
            m_level = 0; m_press = 0; m_release = 0; m_long = 0;
        end else begin
            m_bs = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_in;
            m_changed = (m_bs != m_prev);
            m_prev = m_bs;
            m_press = 0; m_release = 0; m_long = 0;
            // ticks seen while btn_s has been steady
            if (m_changed) m_run = 0;
            else if (tick_1ms) m_run = m_run + 1;
            // long-press: ticks of steady high since acceptance / re-press
            if (m_level && m_bs) begin
                if (m_changed) m_long_run = 0;
                else if (tick_1ms && !m_fired) begin
                    m_long_run = m_long_run + 1;
                    if (m_long_run == LONG) begin
                        m_long  = 1;
                        m_fired = 1;
                    end
                end
            end
            // acceptance on the DEB-th steady tick of a new level
            if (!m_changed && tick_1ms && m_run == DEB && m_bs != m_level) begin
                m_level = m_bs;
                if (m_bs) begin
                    m_press = 1; m_fired = 0; m_long_run = 0;
                end else begin
                    m_release = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus event bookkeeping
    always @(negedge clk) begin
        n_checks = n_checks + 1;
        if ({btn_level, press_pulse, release_pulse, long_pulse} !==
            {m_level, m_press, m_release, m_long}) begin
            n_fail = n_fail + 1;
            $display("FAIL model_cmp t=%0t dut{lvl,prs,rel,lng}=%b%b%b%b model=%b%b%b%b",
                     $time, btn_level, press_pulse, release_pulse, long_pulse,
                     m_level, m_press, m_release, m_long);
        end
        if (press_pulse)   begin n_press   = n_press + 1;   press_tick   = tick_no; end
        if (release_pulse) begin n_release = n_release + 1; release_tick = tick_no; end
        if (long_pulse)    begin n_long    = n_long + 1;    long_tick    = tick_no; end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Returns just after a rising edge that sampled a tick
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!tick_1ms);
        end
    endtask

    int t0, tr, tb_, p0, r0, l0;

    initial begin
        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse}, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // ---- clean press ----
        p0 = n_press; l0 = n_long;
        wait_ticks(1);
        @(negedge clk); btn_in = 1'b1; t0 = tick_no;
        wait_ticks(4);
        @(negedge clk);
        check("press_count", n_press - p0, 1);
        check("press_tick", press_tick - t0, 3);
        check("press_level", btn_level, 1);
        check("model_level_pin", m_level, 1);
        check("no_early_long", n_long - l0, 0);

        // ---- asynchronous reset in PRESSED ----
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {btn_level, press_pulse, release_pulse, long_pulse}, 0);
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p0 = n_press; r0 = n_release; l0 = n_long;
        repeat (60) @(negedge clk);
        check("post_reset_pulses", (n_press - p0) + (n_release - r0) + (n_long - l0), 0);
        check("post_reset_level", btn_level, 0);

        // ---- long press then release ----
        p0 = n_press; r0 = n_release; l0 = n_long;
        wait_ticks(1);
        @(negedge clk); btn_in = 1'b1; t0 = tick_no;
        wait_ticks(12);
        @(negedge clk);
        check("long_press_count", n_press - p0, 1);
        check("long_press_tick", press_tick - t0, 3);
        check("long_count", n_long - l0, 1);
        check("long_tick", long_tick - t0, 8);
        btn_in = 1'b0; tr = tick_no;
        wait_ticks(4);
        @(negedge clk);
        check("release_count", n_release - r0, 1);
        check("release_tick", release_tick - tr, 3);
        check("release_level", btn_level, 0);

        // ---- release bounce before and after long press ----
        r0 = n_release; l0 = n_long;
        wait_ticks(1);
        @(negedge clk); btn_in = 1'b1; t0 = tick_no;
        wait_ticks(5);
        @(negedge clk); btn_in = 1'b0;
        wait_ticks(1);
        @(negedge clk); btn_in = 1'b1; tb_ = tick_no;
        wait_ticks(6);
        @(negedge clk);
        check("bounce_no_release", n_release - r0, 0);
        check("bounce_level", btn_level, 1);
        check("bounce_long_count", n_long - l0, 1);
        check("bounce_long_tick", long_tick - tb_, 5);
        btn_in = 1'b0;
        wait_ticks(1);
        @(negedge clk); btn_in = 1'b1;
        wait_ticks(8);
        @(negedge clk);
        check("held_no_second_long", n_long - l0, 1);
        check("held_no_release", n_release - r0, 0);
        btn_in = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        check("bounce_final_release", n_release - r0, 1);

        // ---- press bounce rejection ----
        p0 = n_press;
        repeat (4) begin
            btn_in = 1'b1; repeat (15) @(negedge clk);
            btn_in = 1'b0; repeat (15) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        check("bounce_reject_press", n_press - p0, 0);
        check("bounce_reject_level", btn_level, 0);

        // ---- drop coincident with the accepting tick ----
        p0 = n_press;
        wait_ticks(1);
        @(negedge clk); btn_in = 1'b1;
        repeat (27) @(negedge clk);
        btn_in = 1'b0;
        repeat (40) @(negedge clk);
        check("priority_no_press", n_press - p0, 0);
        check("priority_level", btn_level, 0);

        // ---- randomized traffic, periodic then random ticks ----
        for (int m = 0; m < 2; m++) begin
            tick_mode = m;
            for (int k = 0; k < 150; k++) begin
                int hold;
                btn_in = ~btn_in;
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20)
                                                   : $urandom_range(20, 130);
                repeat (hold) @(negedge clk);
            end
        end
        tick_mode = 0;
        btn_in = 1'b0;
        repeat (100) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
